// File: rtl/apb_pkg.sv
// Shared types and constants for the APB4 memory completer.
package apb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  localparam int WAIT_W = 4;

  localparam logic APB_OKAY   = 1'b0;
  localparam logic APB_SLVERR = 1'b1;

endpackage

// File: rtl/apb_byte_mem.sv
// DEPTH x DW flop memory: combinational read port, one byte-enabled write port.
module apb_byte_mem #(
  parameter int AW    = 4,
  parameter int DW    = 32,
  parameter int DEPTH = 16
) (
  input  logic            pclk,
  input  logic            we,
  input  logic [AW-1:0]   addr,
  input  logic [DW-1:0]   wdata,
  input  logic [DW/8-1:0] be,
  output logic [DW-1:0]   rdata
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic          in_range;

  assign in_range = ({1'b0, addr} < DEPTH_L);
  assign rdata    = in_range ? mem[addr] : '0;

  // Contents deliberately have no reset.
  always_ff @(posedge pclk) begin
    if (we && in_range) begin
      for (int i = 0; i < DW/8; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/apb4_mem_slave.sv
// APB4 completer over a byte-writable flop memory with per-direction wait states.
//  state  | meaning
//  IDLE   | no transfer in flight; a setup phase loads cnt, err_q and read data
//  ACCESS | access phase; cnt counts down wait cycles, pready when it reaches zero
module apb4_mem_slave
  import apb_pkg::*;
#(
  parameter int AW      = 4,
  parameter int DW      = 32,
  parameter int DEPTH   = 16,
  parameter int RD_WAIT = 0,
  parameter int WR_WAIT = 1
) (
  input  logic            pclk,
  input  logic            prst,
  input  logic            psel,
  input  logic            penable,
  input  logic            pwrite,
  input  logic [AW-1:0]   paddr,
  input  logic [DW-1:0]   pwdata,
  input  logic [DW/8-1:0] pstrb,
  output logic            pready,
  output logic [DW-1:0]   prdata,
  output logic            pslverr
);

  localparam logic [AW:0]       DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [WAIT_W-1:0] RD_CNT  = WAIT_W'(RD_WAIT);
  localparam logic [WAIT_W-1:0] WR_CNT  = WAIT_W'(WR_WAIT);

  apb_state_e        state, state_nxt;
  logic [WAIT_W-1:0] cnt, cnt_nxt;
  logic              err_q;
  logic              in_range;
  logic              setup;
  logic              mem_we;
  logic [DW-1:0]     mem_rdata;

  assign in_range = ({1'b0, paddr} < DEPTH_L);
  assign setup    = (state == IDLE) && psel && !penable;

  // Registered-only decode keeps pready free of any bus input path.
  assign pready  = (state == ACCESS) && (cnt == '0);
  assign pslverr = pready & err_q;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mem_we    = 1'b0;
    case (state)
      IDLE: begin
        if (setup) begin
          state_nxt = ACCESS;
          cnt_nxt   = pwrite ? WR_CNT : RD_CNT;
        end
      end
      ACCESS: begin
        if (!(psel && penable)) begin
          state_nxt = IDLE;
        end else if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          state_nxt = IDLE;
          mem_we    = pwrite && (err_q == APB_OKAY);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      state  <= IDLE;
      cnt    <= '0;
      err_q  <= APB_OKAY;
      prdata <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (setup) begin
        err_q <= in_range ? APB_OKAY : APB_SLVERR;
        if (!pwrite) prdata <= in_range ? mem_rdata : '0;
      end
    end
  end

  apb_byte_mem #(
    .AW    (AW),
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_mem (
    .pclk  (pclk),
    .we    (mem_we),
    .addr  (paddr),
    .wdata (pwdata),
    .be    (pstrb),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_apb4_mem_slave.sv
// Directed bench: dut_a (DEPTH=12, RD_WAIT=0, WR_WAIT=1), dut_b (DEPTH=16, RD_WAIT=2, WR_WAIT=3).
module tb_apb4_mem_slave;

  logic        pclk = 1'b0;
  logic        prst = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [3:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic        use_b = 1'b0;

  logic        pready_a, pslverr_a, pready_b, pslverr_b;
  logic [31:0] prdata_a, prdata_b;
  logic        pready, pslverr;
  logic [31:0] prdata;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  logic [31:0] xr_data;
  logic        xr_err;
  int          xr_cyc;

  always #5 pclk = ~pclk;

  assign pready  = use_b ? pready_b  : pready_a;
  assign pslverr = use_b ? pslverr_b : pslverr_a;
  assign prdata  = use_b ? prdata_b  : prdata_a;

  apb4_mem_slave #(.AW(4), .DW(32), .DEPTH(12), .RD_WAIT(0), .WR_WAIT(1)) dut_a (
    .pclk(pclk), .prst(prst), .psel(psel & ~use_b), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready_a), .prdata(prdata_a), .pslverr(pslverr_a));

  apb4_mem_slave #(.AW(4), .DW(32), .DEPTH(16), .RD_WAIT(2), .WR_WAIT(3)) dut_b (
    .pclk(pclk), .prst(prst), .psel(psel & use_b), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready_b), .prdata(prdata_b), .pslverr(pslverr_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Setup then access phases; returns at the negedge where pready is seen high.
  task automatic xfer(input logic wr, input logic [3:0] a, input logic [31:0] d,
                      input logic [3:0] s);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    @(negedge pclk);
    penable = 1'b1;
    xr_cyc  = 1;
    while (!pready && xr_cyc < 20) begin
      @(negedge pclk);
      xr_cyc++;
    end
    if (!pready) chk("pready_timeout", 32'(pready), 32'd1);
    xr_data = prdata;
    xr_err  = pslverr;
  endtask

  task automatic bus_idle();
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge pclk);
    chk("rst_pready_a", 32'(pready_a), 32'd0);
    chk("rst_pslverr_a", 32'(pslverr_a), 32'd0);
    chk("rst_prdata_a", prdata_a, 32'h0);
    chk("rst_prdata_b", prdata_b, 32'h0);
    prst = 1'b1;

    // dut_a: basic write/readback and byte lanes
    xfer(1'b1, 4'd3, 32'hDEADBEEF, 4'hF);
    chk("wr3_cycles", 32'(xr_cyc), 32'd2);
    chk("wr3_err", 32'(xr_err), 32'd0);
    xfer(1'b0, 4'd3, 32'h0, 4'h0);
    chk("rd3_cycles", 32'(xr_cyc), 32'd1);
    chk("rd3_data", xr_data, 32'hDEADBEEF);
    xfer(1'b1, 4'd3, 32'h11223344, 4'b0101);
    chk("wr3_strb_prdata_hold", xr_data, 32'hDEADBEEF);
    xfer(1'b0, 4'd3, 32'h0, 4'h0);
    chk("rd3_strb_data", xr_data, 32'hDE22BE44);

    // range error and last valid word
    xfer(1'b1, 4'd13, 32'hCAFEF00D, 4'hF);
    chk("wr13_err", 32'(xr_err), 32'd1);
    chk("wr13_cycles", 32'(xr_cyc), 32'd2);
    xfer(1'b0, 4'd13, 32'h0, 4'h0);
    chk("rd13_err", 32'(xr_err), 32'd1);
    chk("rd13_data", xr_data, 32'h0);
    xfer(1'b1, 4'd11, 32'h0BADF00D, 4'hF);
    chk("wr11_err", 32'(xr_err), 32'd0);
    xfer(1'b0, 4'd11, 32'h0, 4'h0);
    chk("rd11_data", xr_data, 32'h0BADF00D);
    chk("rd11_err", 32'(xr_err), 32'd0);

    // zero strobe leaves memory alone
    xfer(1'b1, 4'd3, 32'h0, 4'h0);
    chk("wr3_nostrb_err", 32'(xr_err), 32'd0);
    xfer(1'b0, 4'd3, 32'h0, 4'h0);
    chk("rd3_after_err_nostrb", xr_data, 32'hDE22BE44);
    bus_idle();

    // dut_b: abort mid-wait
    use_b = 1'b1;
    xfer(1'b1, 4'd5, 32'hA5A5A5A5, 4'hF);
    chk("b_wr5_cycles", 32'(xr_cyc), 32'd4);
    bus_idle();
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'd5; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
    @(negedge pclk);
    penable = 1'b1;
    chk("abort_acc1_pready", 32'(pready), 32'd0);
    @(negedge pclk);
    chk("abort_acc2_pready", 32'(pready), 32'd0);
    psel = 1'b0; penable = 1'b0;
    @(negedge pclk);
    chk("abort_after_pready", 32'(pready), 32'd0);
    xfer(1'b0, 4'd5, 32'h0, 4'h0);
    chk("b_rd5_data", xr_data, 32'hA5A5A5A5);
    chk("b_rd5_cycles", 32'(xr_cyc), 32'd3);

    // back-to-back writes then reads, no idle gap
    for (int i = 0; i < 4; i++) xfer(1'b1, 4'(i), 32'h1000_0000 + 32'(i * 17), 4'hF);
    for (int i = 0; i < 4; i++) begin
      xfer(1'b0, 4'(i), 32'h0, 4'h0);
      chk($sformatf("b2b_rd%0d_cycles", i), 32'(xr_cyc), 32'd3);
      chk($sformatf("b2b_rd%0d_data", i), xr_data, 32'h1000_0000 + 32'(i * 17));
    end
    bus_idle();
    use_b = 1'b0;

    // async reset in the middle of a read access on dut_a
    xfer(1'b0, 4'd3, 32'h0, 4'h0);
    chk("pre_rst_prdata", prdata, 32'hDE22BE44);
    #1 prst = 1'b0;
    #1;
    chk("midrst_pready", 32'(pready), 32'd0);
    chk("midrst_pslverr", 32'(pslverr), 32'd0);
    chk("midrst_prdata", prdata, 32'h0);
    @(negedge pclk);
    chk("midrst_hold_pready", 32'(pready), 32'd0);
    psel = 1'b0; penable = 1'b0;
    prst = 1'b1;
    xfer(1'b0, 4'd3, 32'h0, 4'h0);
    chk("post_rst_rd3", xr_data, 32'hDE22BE44);
    bus_idle();

    repeat (2) @(negedge pclk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
